sram_arbiter: RTL

Two-master arbiter and command sequencer for the registered SRAM bridge (Avalon-style side: address, cs_n, read_n, write_n, byteenable_n, data_write, data_read). It shares the single SRAM between master 0 (video/DMA fetch) and master 1 (CPU data port). It issues at most one command per cycle, inserts bus turnaround and write-recovery idle cycles, and routes returned read data back to its owner.

---
 rtl/sram_arbiter_if.sv | 25 ++
 rtl/sram_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Request/response channel between one SRAM master and the arbiter.
// The master holds req and its fields stable until it sees gnt.
interface sram_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master SRAM command sequencer: arbitrates, inserts turnaround and
// write-recovery idles, and steers read returns back to the issuing master.
module sram_arbiter #(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 16,
    parameter int READ_LATENCY  = 2,
    parameter int PRIORITY_MODE = 1
) (
    input  logic                clk,
    input  logic                reset,
    sram_arbiter_if.slave       m0,
    sram_arbiter_if.slave       m1,
    output logic [ADDR_W-1:0]   sram_address,
    output logic                sram_cs_n,
    output logic                sram_read_n,
    output logic                sram_write_n,
    output logic [DATA_W/8-1:0] sram_byteenable_n,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t                  state_q, state_d;
    logic                    pref_q, pref_d;
    logic [READ_LATENCY-1:0] tag_vld_q;
    logic [READ_LATENCY-1:0] tag_own_q;
    logic                    rvalid0_q, rvalid1_q;

    logic                    win;
    logic                    win_we;
    logic                    allow;
    logic [ADDR_W-1:0]       win_addr;
    logic [BE_W-1:0]         win_be;
    logic [DATA_W-1:0]       win_wdata;

    // Winner is chosen first; the state then only decides whether it may go,
    // so a blocked write is never overtaken by the other master's read.
    always_comb begin
        if (m0.req && m1.req) begin
            win = (PRIORITY_MODE == 0) ? 1'b0 : pref_q;
        end else begin
            win = m1.req & ~m0.req;
        end
        win_we    = win ? m1.we    : m0.we;
        win_addr  = win ? m1.addr  : m0.addr;
        win_be    = win ? m1.be    : m0.be;
        win_wdata = win ? m1.wdata : m0.wdata;

        case (state_q)
            IDLE:    allow = m0.req | m1.req;
            RD:      allow = (m0.req | m1.req) & ~win_we;
            default: allow = 1'b0;
        endcase
        if (reset) begin
            allow = 1'b0;
        end

        state_d = IDLE;
        if (allow) begin
            state_d = win_we ? WR : RD;
        end
        pref_d = allow ? ~win : pref_q;
    end

    assign m0.gnt    = allow & ~win;
    assign m1.gnt    = allow & win;
    assign m0.rvalid = rvalid0_q;
    assign m1.rvalid = rvalid1_q;
    assign m0.rdata  = sram_rdata;
    assign m1.rdata  = sram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            pref_q            <= 1'b0;
            sram_cs_n         <= 1'b1;
            sram_read_n       <= 1'b1;
            sram_write_n      <= 1'b1;
            sram_byteenable_n <= '1;
            sram_address      <= '0;
            sram_wdata        <= '0;
            tag_vld_q         <= '0;
            tag_own_q         <= '0;
            rvalid0_q         <= 1'b0;
            rvalid1_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pref_q       <= pref_d;
            sram_cs_n    <= ~allow;
            sram_read_n  <= ~(allow & ~win_we);
            sram_write_n <= ~(allow & win_we);
            if (allow) begin
                sram_address      <= win_addr;
                sram_byteenable_n <= ~win_be;
                if (win_we) begin
                    sram_wdata <= win_wdata;
                end
            end
            // Stage 0 is loaded as the read goes onto the bus; the final
            // rvalid register adds the last cycle of bridge latency.
            tag_vld_q[0] <= allow & ~win_we;
            tag_own_q[0] <= win;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end
            rvalid0_q <= tag_vld_q[READ_LATENCY-1] & ~tag_own_q[READ_LATENCY-1];
            rvalid1_q <= tag_vld_q[READ_LATENCY-1] & tag_own_q[READ_LATENCY-1];
        end
    end
endmodule
